// File: rtl/nios2_debug_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : nios2_debug_pkg                                            |
// | Shared types and constants for the Nios II debug scan master:        |
// | scan phase encoding, virtual IR codes and data register width.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package nios2_debug_pkg;

  localparam int DEBUG_DR_W = 38;
  localparam int DEBUG_IR_W = 2;

  // Virtual IR codes understood by the debug slave
  localparam logic [1:0] IR_OCIMEM   = 2'd0;
  localparam logic [1:0] IR_TRACE    = 2'd1;
  localparam logic [1:0] IR_BREAK    = 2'd2;
  localparam logic [1:0] IR_TRACEMEM = 2'd3;

  // Scan phases; explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RTI  = 3'd5,
    DONE = 3'd6
  } scan_state_t;

  // Counter width for values 0..v-1, never narrower than one bit
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_debug_tck_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nios2_debug_tck_gen                                        |
// | Divides clk into a test clock: TCK_HALF clks low, TCK_HALF clks      |
// | high per period.                                                     |
// | Ports   : clk, reset_n (sync, active low), en (run), clear (park     |
// |           tck low while disabled), tck, rise_en (clk that drives     |
// |           tck 0->1), period_end (clk that drives tck 1->0)           |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module nios2_debug_tck_gen
  import nios2_debug_pkg::*;
#(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic tck,
  output logic rise_en,
  output logic period_end
);

  localparam int              HC_W    = clog2_min1(TCK_HALF);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(TCK_HALF - 1);

  logic [HC_W-1:0] half_cnt;
  logic            half_end;

  assign half_end   = en && (half_cnt == HC_LAST);
  assign rise_en    = half_end && !tck;
  assign period_end = half_end && tck;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      half_cnt <= '0;
      tck      <= 1'b0;
    end else if (en) begin
      if (half_cnt == HC_LAST) begin
        half_cnt <= '0;
        tck      <= ~tck;
      end else begin
        half_cnt <= half_cnt + HC_W'(1);
      end
    end else if (clear) begin
      half_cnt <= '0;
      tck      <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nios2_debug_scan_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nios2_debug_scan_master                                    |
// | Drives one virtual-JTAG scan (UIR -> CDR -> SDR -> UDR -> RTI) into  |
// | the Nios II debug slave per accepted command and returns the bits    |
// | shifted out on vji_tdo.                                              |
// | Ports   : clk, reset_n (sync, active low)                            |
// |           cmd_valid/cmd_ready, cmd_ir, cmd_dr, cmd_skip_dr : command |
// |           rsp_valid (1-clk pulse), rsp_dr : captured data           |
// |           busy : not ready for a command                             |
// |           vji_tck/tdi/tdo/ir_in + uir/cdr/sdr/udr/rti : to slave     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module nios2_debug_scan_master
  import nios2_debug_pkg::*;
#(
  parameter int IR_W     = DEBUG_IR_W,
  parameter int DR_W     = DEBUG_DR_W,
  parameter int TCK_HALF = 2,
  parameter int RTI_TCKS = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  input  logic            cmd_skip_dr,
  output logic            rsp_valid,
  output logic [DR_W-1:0] rsp_dr,
  output logic            busy,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  localparam int BC_W = clog2_min1((DR_W > RTI_TCKS) ? DR_W : RTI_TCKS);

  scan_state_t     state;
  scan_state_t     state_nx;
  logic            tck_en;
  logic            rise_en;
  logic            period_end;
  logic            accept;
  logic            skip_dr;
  logic [DR_W-1:0] dr_sh;
  logic [BC_W-1:0] bit_cnt;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign tck_en    = (state == UIR) || (state == CDR) || (state == SDR) ||
                     (state == UDR) || (state == RTI);

  nios2_debug_tck_gen #(
    .TCK_HALF (TCK_HALF)
  ) u_tck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (tck_en),
    .clear      (~tck_en),
    .tck        (vji_tck),
    .rise_en    (rise_en),
    .period_end (period_end)
  );

  // Phase sequencing: every scan phase ends on a tck period boundary
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cmd_valid)                      state_nx = UIR;
      UIR:  if (period_end)                     state_nx = skip_dr ? RTI : CDR;
      CDR:  if (period_end)                     state_nx = SDR;
      SDR:  if (period_end && (bit_cnt == '0))  state_nx = UDR;
      UDR:  if (period_end)                     state_nx = RTI;
      RTI:  if (period_end && (bit_cnt == '0))  state_nx = DONE;
      DONE:                                     state_nx = IDLE;
      default:                                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      skip_dr   <= 1'b0;
      dr_sh     <= '0;
      bit_cnt   <= '0;
      vji_ir_in <= '0;
      vji_tdi   <= 1'b0;
      rsp_dr    <= '0;
      rsp_valid <= 1'b0;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_rti   <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_valid <= (state_nx == DONE);

      // Strobes come from the next state so they switch on the same
      // edge as the phase, i.e. only at tck period boundaries.
      vji_uir <= (state_nx == UIR);
      vji_cdr <= (state_nx == CDR);
      vji_sdr <= (state_nx == SDR);
      vji_udr <= (state_nx == UDR);
      vji_rti <= (state_nx == RTI);

      if (accept) begin
        vji_ir_in <= cmd_ir;
        skip_dr   <= cmd_skip_dr;
        dr_sh     <= cmd_dr;
        rsp_dr    <= '0;
      end

      // One counter serves both SDR bit count and RTI period count
      if ((state == CDR) && period_end) begin
        bit_cnt <= BC_W'(DR_W - 1);
      end else if ((state_nx == RTI) && (state != RTI)) begin
        bit_cnt <= BC_W'(RTI_TCKS - 1);
      end else if (period_end && ((state == SDR) || (state == RTI))) begin
        bit_cnt <= bit_cnt - BC_W'(1);
      end

      // Present the next DR bit at the start of each SDR period
      if ((state_nx == SDR) && ((state != SDR) || period_end)) begin
        vji_tdi <= dr_sh[0];
        dr_sh   <= {1'b0, dr_sh[DR_W-1:1]};
      end else if (state_nx != SDR) begin
        vji_tdi <= 1'b0;
      end

      // Sample tdo just before the slave shifts; bits enter from the top
      // so the first captured bit ends up in rsp_dr[0].
      if ((state == SDR) && rise_en) begin
        rsp_dr <= {vji_tdo, rsp_dr[DR_W-1:1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_scan_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_nios2_debug_scan_master                                 |
// | Bench for nios2_debug_scan_master: two instances (default timing and |
// | TCK_HALF=1/RTI_TCKS=1), each with a 38-bit slave model, a scoreboard |
// | queue and an independent response monitor.                          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_nios2_debug_scan_master;
  import nios2_debug_pkg::*;

  localparam int DRW = DEBUG_DR_W;

  typedef struct {
    logic [1:0]     ir;
    logic [DRW-1:0] dr;
    logic [DRW-1:0] cap;
    logic           skip;
    int             acc;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  logic clk    = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input int inst, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL u%0d.%s: got %0h required %0h", inst, name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int TH = (g == 0) ? 2 : 1;
    localparam int RT = (g == 0) ? 2 : 1;

    logic           reset_n, cmd_valid, cmd_ready, cmd_skip_dr, rsp_valid, busy;
    logic           vji_tck, vji_tdi, vji_tdo;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic [1:0]     cmd_ir, vji_ir_in;
    logic [DRW-1:0] cmd_dr, rsp_dr;

    bit   fin     = 1'b0;
    int   cyc     = 0;
    int   rsp_cyc = -100;
    exp_t exp_q[$];

    nios2_debug_scan_master #(
      .IR_W     (2),
      .DR_W     (DRW),
      .TCK_HALF (TH),
      .RTI_TCKS (RT)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_ir      (cmd_ir),
      .cmd_dr      (cmd_dr),
      .cmd_skip_dr (cmd_skip_dr),
      .rsp_valid   (rsp_valid),
      .rsp_dr      (rsp_dr),
      .busy        (busy),
      .vji_tck     (vji_tck),
      .vji_tdi     (vji_tdi),
      .vji_tdo     (vji_tdo),
      .vji_ir_in   (vji_ir_in),
      .vji_uir     (vji_uir),
      .vji_cdr     (vji_cdr),
      .vji_sdr     (vji_sdr),
      .vji_udr     (vji_udr),
      .vji_rti     (vji_rti)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: capture CAP in cdr, shift right in sdr, tdo = sr[0].
    // Per-scan strobe counters restart whenever a uir period is seen.
    logic [DRW-1:0] sr        = '0;
    logic [DRW-1:0] sr_at_udr = '0;
    logic [1:0]     ir_seen   = '0;
    int n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;

    assign vji_tdo = sr[0];

    always @(posedge vji_tck) begin
      if (vji_uir) begin
        ir_seen <= vji_ir_in;
        n_cdr   <= 0;
        n_sdr   <= 0;
        n_udr   <= 0;
        n_rti   <= 0;
      end
      if (vji_cdr) begin
        sr    <= (exp_q.size() > 0) ? exp_q[0].cap : '0;
        n_cdr <= n_cdr + 1;
      end
      if (vji_sdr) begin
        sr    <= {vji_tdi, sr[DRW-1:1]};
        n_sdr <= n_sdr + 1;
      end
      if (vji_udr) begin
        sr_at_udr <= sr;
        n_udr     <= n_udr + 1;
      end
      if (vji_rti) n_rti <= n_rti + 1;
    end

    // Monitor: protocol flags every clk, scoreboard compare on rsp_valid
    int   bad_overlap = 0, bad_idle_tck = 0, bad_pulse = 0;
    logic prev_rsp    = 1'b0;

    initial begin
      exp_t e;
      int   n_periods;
      forever begin
        @(negedge clk);
        if (reset_n === 1'b1) begin
          if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) bad_overlap++;
          if (cmd_ready && vji_tck) bad_idle_tck++;
          if (rsp_valid && prev_rsp) bad_pulse++;
          if (rsp_valid) begin
            rsp_cyc = cyc;
            chk(g, "rsp_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              n_periods = e.skip ? (1 + RT) : (3 + DRW + RT);
              chk(g, "latency", 64'(cyc + 1 - e.acc), 64'(n_periods * 2 * TH + 1));
              chk(g, "rsp_dr", 64'(rsp_dr), e.skip ? 64'(0) : 64'(e.cap));
              chk(g, "ir_at_uir", 64'(ir_seen), 64'(e.ir));
              chk(g, "ir_in_held", 64'(vji_ir_in), 64'(e.ir));
              chk(g, "sdr_rises", 64'(n_sdr), e.skip ? 64'(0) : 64'(DRW));
              chk(g, "cdr_rises", 64'(n_cdr), e.skip ? 64'(0) : 64'(1));
              chk(g, "udr_rises", 64'(n_udr), e.skip ? 64'(0) : 64'(1));
              chk(g, "rti_rises", 64'(n_rti), 64'(RT));
              if (!e.skip) chk(g, "slave_sr_at_udr", 64'(sr_at_udr), 64'(e.dr));
              chk(g, "strobe_overlap", 64'(bad_overlap), 64'(0));
              chk(g, "tck_high_idle", 64'(bad_idle_tck), 64'(0));
              chk(g, "rsp_pulse_width", 64'(bad_pulse), 64'(0));
            end
          end
        end
        prev_rsp = rsp_valid;
      end
    end

    // Offer a command (called just after a negedge) and wait for accept
    task automatic issue(input logic [1:0] ir, input logic [DRW-1:0] dr,
                         input logic [DRW-1:0] cap, input logic skp,
                         input bit keep, output int acc);
      exp_t e;
      cmd_ir      = ir;
      cmd_dr      = dr;
      cmd_skip_dr = skp;
      cmd_valid   = 1'b1;
      for (int i = 0; i < 1000 && !cmd_ready; i++) @(negedge clk);
      acc = cyc + 1;
      chk(g, "accept_wait", 64'(cmd_ready), 64'(1));
      e.ir   = ir;
      e.dr   = dr;
      e.cap  = cap;
      e.skip = skp;
      e.acc  = acc;
      if (cmd_ready) exp_q.push_back(e);
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic drain();
      for (int i = 0; i < 1000 && exp_q.size() > 0; i++) @(negedge clk);
      chk(g, "rsp_wait", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    endtask

    function automatic logic [DRW-1:0] rnd_dr();
      return DRW'({$urandom(), $urandom()});
    endfunction

    initial begin
      int             a1, a2;
      logic [DRW-1:0] d;
      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_ir      = '0;
      cmd_dr      = '0;
      cmd_skip_dr = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk(g, "reset_ready", 64'(cmd_ready), 64'(1));
      chk(g, "reset_tck", 64'(vji_tck), 64'(0));
      chk(g, "reset_rsp_dr", 64'(rsp_dr), 64'(0));
      chk(g, "reset_ir_in", 64'(vji_ir_in), 64'(0));

      // Directed scan with known data and capture value
      issue(IR_OCIMEM, 38'h2A_5A5A_5A5A, 38'h15_DEAD_BEEF, 1'b0, 1'b0, a1);
      drain();

      // Back-to-back with cmd_valid held
      issue(IR_BREAK, rnd_dr(), rnd_dr(), 1'b0, 1'b1, a1);
      issue(IR_TRACE, rnd_dr(), rnd_dr(), 1'b0, 1'b0, a2);
      chk(g, "b2b_accept_gap", 64'(a2 - rsp_cyc), 64'(2));
      drain();

      // IR-only update
      issue(IR_TRACEMEM, rnd_dr(), rnd_dr(), 1'b1, 1'b0, a1);
      drain();

      // Reset during SDR bit 17: scan is dropped without a response
      issue(IR_TRACE, rnd_dr(), rnd_dr(), 1'b0, 1'b0, a1);
      for (int i = 0; i < 1000 && !(vji_sdr && n_sdr == 17); i++) @(negedge clk);
      chk(g, "reached_bit17", 64'(n_sdr), 64'(17));
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      chk(g, "midreset_idle", 64'(cmd_ready), 64'(1));
      chk(g, "midreset_tck", 64'(vji_tck), 64'(0));
      chk(g, "midreset_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'(0));
      chk(g, "midreset_rsp_dr", 64'(rsp_dr), 64'(0));
      chk(g, "midreset_rsp_valid", 64'(rsp_valid), 64'(0));
      repeat (60) @(negedge clk);
      issue(IR_OCIMEM, rnd_dr(), rnd_dr(), 1'b0, 1'b0, a1);
      drain();

      // A new command offered while busy is ignored
      d = rnd_dr();
      issue(IR_BREAK, d, rnd_dr(), 1'b0, 1'b0, a1);
      repeat (20) @(negedge clk);
      cmd_ir    = IR_TRACEMEM;
      cmd_dr    = ~d;
      cmd_valid = 1'b1;
      chk(g, "ready_while_busy", 64'(cmd_ready), 64'(0));
      chk(g, "busy_flag", 64'(busy), 64'(1));
      @(negedge clk);
      cmd_valid = 1'b0;
      drain();

      // Randomised scans
      for (int k = 0; k < 5; k++) begin
        issue(2'($urandom_range(0, 3)), rnd_dr(), rnd_dr(),
              ($urandom_range(0, 3) == 0), 1'b0, a1);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        drain();
      end
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (g_dut[0].fin && g_dut[1].fin) break;
    end
    chk(9, "all_done", 64'(g_dut[0].fin && g_dut[1].fin), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
